// File: rtl/mips_fetch_unit_if.sv
// Bundles the core-facing and instruction-memory-facing signals of the fetch stage.
// The master side belongs to the fetch unit; the slave side is the core and the memory.
interface mips_fetch_unit_if;
  logic [31:0] pc;
  logic [31:0] pc_new;
  logic        core_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output pc, instr, instr_valid, imem_req, imem_addr,
    input  pc_new, core_ready, imem_ack, imem_rdata
  );

  modport slave (
    input  pc, instr, instr_valid, imem_req, imem_addr,
    output pc_new, core_ready, imem_ack, imem_rdata
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage for the single-cycle MIPS core: owns the PC, fetches over
// a req/ack memory handshake and hands each instruction to the core until it commits.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mips_fetch_unit_if.master        bus,
  output logic                     fault,
  output logic [1:0]               fault_code,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;
  localparam logic [1:0]  CODE_TIMEOUT = 2'b01;
  localparam logic [1:0]  CODE_ALIGN   = 2'b10;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [15:0] wait_reg;
  logic        fault_reg;
  logic [1:0]  fault_code_reg;
  logic [31:0] stall_reg;
  logic [31:0] count_reg;

  logic timeout_hit;
  logic misaligned;

  assign timeout_hit = (TIMEOUT != 16'd0) && (wait_reg == TIMEOUT_LAST);
  assign misaligned  = |bus.pc_new[1:0];

  // State register; async reset drops imem_req the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          state_next = HOLD;
        end else if (timeout_hit) begin
          state_next = FAULT;
        end
      end
      HOLD: begin
        if (bus.core_ready) begin
          state_next = misaligned ? FAULT : FETCH;
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    case (state_reg)
      FETCH:   bus.imem_req    = 1'b1;
      HOLD:    bus.instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers; each only moves in the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      instr_reg      <= 32'd0;
      wait_reg       <= 16'd0;
      fault_reg      <= 1'b0;
      fault_code_reg <= 2'b00;
      stall_reg      <= 32'd0;
      count_reg      <= 32'd0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (bus.imem_ack) begin
            instr_reg <= bus.imem_rdata;
            wait_reg  <= 16'd0;
          end else begin
            wait_reg <= wait_reg + 16'd1;
            if (stall_reg != 32'hFFFF_FFFF) begin
              stall_reg <= stall_reg + 32'd1;
            end
            if (timeout_hit) begin
              fault_reg      <= 1'b1;
              fault_code_reg <= CODE_TIMEOUT;
            end
          end
        end
        HOLD: begin
          if (bus.core_ready) begin
            if (misaligned) begin
              fault_reg      <= 1'b1;
              fault_code_reg <= CODE_ALIGN;
            end else begin
              pc_reg    <= bus.pc_new;
              count_reg <= count_reg + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc        = pc_reg;
  assign bus.imem_addr = pc_reg;
  assign bus.instr     = instr_reg;
  assign fault         = fault_reg;
  assign fault_code    = fault_code_reg;
  assign stall_cycles  = stall_reg;
  assign instr_count   = count_reg;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: cycle-by-cycle vector tables plus hand-written
// sequences for asynchronous reset in the middle of a fetch.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] stall_cycles;
  logic [31:0] instr_count;

  int n_vec = 0;
  int miscompares = 0;

  mips_fetch_unit_if bus ();

  mips_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16'd8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .fault        (fault),
    .fault_code   (fault_code),
    .stall_cycles (stall_cycles),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] pc_new;
    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  code;
    logic [31:0] stall;
    logic [31:0] count;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];

  localparam logic [31:0] I0 = 32'h2008_0001, I1 = 32'h2009_0002, I2 = 32'h0109_5020;
  localparam logic [31:0] I3 = 32'hAC0A_0000, I4 = 32'h8C08_0010, I5 = 32'h1000_FFFF;
  localparam logic [31:0] I6 = 32'h0800_0010, I7 = 32'h2010_0007, I8 = 32'h2011_0008;
  localparam logic [31:0] G  = 32'hDEAD_BEEF;

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic ready,
                              input logic [31:0] pc_new, input logic req, input logic valid,
                              input logic [31:0] instr, input logic [31:0] pc,
                              input logic [1:0] code, input logic [31:0] stall,
                              input logic [31:0] count);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.pc_new = pc_new;
    v.req = req; v.valid = valid; v.instr = instr; v.pc = pc;
    v.code = code; v.stall = stall; v.count = count;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    n_vec++;
    chk({tag, ".imem_req"},    32'(bus.imem_req),    32'(v.req));
    chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(v.valid));
    chk({tag, ".instr"},       bus.instr,            v.instr);
    chk({tag, ".pc"},          bus.pc,               v.pc);
    chk({tag, ".imem_addr"},   bus.imem_addr,        v.pc);
    chk({tag, ".fault"},       32'(fault),           32'(v.code != 2'b00));
    chk({tag, ".fault_code"},  32'(fault_code),      32'(v.code));
    chk({tag, ".stall"},       stall_cycles,         v.stall);
    chk({tag, ".count"},       instr_count,          v.count);
    $display("%s ack=%b rdy=%b pc_new=%h -> req=%b addr=%h valid=%b instr=%h fault=%b/%b stall=%0d count=%0d",
             tag, v.ack, v.ready, v.pc_new, bus.imem_req, bus.imem_addr, bus.instr_valid,
             bus.instr, fault, fault_code, stall_cycles, instr_count);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic apply(input string tag, input vec_t v);
    bus.imem_ack   = v.ack;
    bus.imem_rdata = v.rdata;
    bus.core_ready = v.ready;
    bus.pc_new     = v.pc_new;
    @(posedge clk);
    #1;
    check_all(tag, v);
  endtask

  initial begin
    // Table A: zero-wait stream, wait states, backpressure, branch, misaligned commit.
    tab_a.push_back(mk(0, 0,  0, 0,        1, 0, 0,  32'h00, 2'b00, 0, 0));
    tab_a.push_back(mk(1, I0, 0, 0,        0, 1, I0, 32'h00, 2'b00, 0, 0));
    tab_a.push_back(mk(0, 0,  1, 32'h04,   1, 0, I0, 32'h04, 2'b00, 0, 1));
    tab_a.push_back(mk(1, I1, 1, 32'h100,  0, 1, I1, 32'h04, 2'b00, 0, 1));
    tab_a.push_back(mk(0, 0,  1, 32'h08,   1, 0, I1, 32'h08, 2'b00, 0, 2));
    tab_a.push_back(mk(1, I2, 0, 0,        0, 1, I2, 32'h08, 2'b00, 0, 2));
    tab_a.push_back(mk(0, 0,  1, 32'h0C,   1, 0, I2, 32'h0C, 2'b00, 0, 3));
    tab_a.push_back(mk(1, I3, 0, 0,        0, 1, I3, 32'h0C, 2'b00, 0, 3));
    tab_a.push_back(mk(0, 0,  1, 32'h10,   1, 0, I3, 32'h10, 2'b00, 0, 4));
    tab_a.push_back(mk(0, 0,  0, 0,        1, 0, I3, 32'h10, 2'b00, 1, 4));
    tab_a.push_back(mk(0, G,  0, 0,        1, 0, I3, 32'h10, 2'b00, 2, 4));
    tab_a.push_back(mk(0, 0,  0, 0,        1, 0, I3, 32'h10, 2'b00, 3, 4));
    tab_a.push_back(mk(1, I4, 0, 0,        0, 1, I4, 32'h10, 2'b00, 3, 4));
    tab_a.push_back(mk(0, 0,  0, 32'h40,   0, 1, I4, 32'h10, 2'b00, 3, 4));
    tab_a.push_back(mk(1, G,  0, 0,        0, 1, I4, 32'h10, 2'b00, 3, 4));
    tab_a.push_back(mk(0, 0,  0, 32'h44,   0, 1, I4, 32'h10, 2'b00, 3, 4));
    tab_a.push_back(mk(0, 0,  0, 0,        0, 1, I4, 32'h10, 2'b00, 3, 4));
    tab_a.push_back(mk(0, 0,  0, 0,        0, 1, I4, 32'h10, 2'b00, 3, 4));
    tab_a.push_back(mk(0, 0,  1, 32'h40,   1, 0, I4, 32'h40, 2'b00, 3, 5));
    tab_a.push_back(mk(1, I5, 0, 0,        0, 1, I5, 32'h40, 2'b00, 3, 5));
    tab_a.push_back(mk(0, 0,  1, 32'h40,   1, 0, I5, 32'h40, 2'b00, 3, 6));
    tab_a.push_back(mk(1, I6, 0, 0,        0, 1, I6, 32'h40, 2'b00, 3, 6));
    tab_a.push_back(mk(0, 0,  1, 32'h42,   0, 0, I6, 32'h40, 2'b10, 3, 6));
    tab_a.push_back(mk(1, G,  1, 32'h44,   0, 0, I6, 32'h40, 2'b10, 3, 6));
    tab_a.push_back(mk(0, 0,  0, 0,        0, 0, I6, 32'h40, 2'b10, 3, 6));

    // Table B: starts in FETCH at pc 0 after reset; pc wrap then timeout with TIMEOUT=8.
    tab_b.push_back(mk(1, I7, 0, 0,            0, 1, I7, 32'h0,         2'b00, 0, 0));
    tab_b.push_back(mk(0, 0,  1, 32'hFFFF_FFFC, 1, 0, I7, 32'hFFFF_FFFC, 2'b00, 0, 1));
    tab_b.push_back(mk(1, I8, 0, 0,            0, 1, I8, 32'hFFFF_FFFC, 2'b00, 0, 1));
    tab_b.push_back(mk(0, 0,  1, 32'h0,        1, 0, I8, 32'h0,         2'b00, 0, 2));
    for (int k = 1; k <= 7; k++) begin
      tab_b.push_back(mk(0, 0, 0, 0,           1, 0, I8, 32'h0,         2'b00, 32'(k), 2));
    end
    tab_b.push_back(mk(0, 0,  0, 0,            0, 0, I8, 32'h0,         2'b01, 8, 2));
    tab_b.push_back(mk(1, G,  0, 0,            0, 0, I8, 32'h0,         2'b01, 8, 2));
    tab_b.push_back(mk(0, 0,  1, 32'h42,       0, 0, I8, 32'h0,         2'b01, 8, 2));

    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.core_ready = 1'b0; bus.pc_new = 32'd0;

    // Reset state while rst_n is held low across several edges.
    repeat (2) @(posedge clk);
    #1;
    check_all("RST", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < tab_a.size(); i++) apply($sformatf("A%0d", i), tab_a[i]);

    // Reset out of FAULT clears everything immediately.
    bus.imem_ack = 1'b0; bus.core_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all("RST_FAULT", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_all("IDLE", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0));
    @(posedge clk); #1;
    check_all("FETCH0", mk(0, 0, 0, 0, 1, 0, 0, 32'h0, 2'b00, 0, 0));

    // Reset asserted mid-FETCH: request must drop before any further edge.
    bus.imem_ack = 1'b1; bus.imem_rdata = G;
    rst_n = 1'b0;
    #1;
    check_all("RST_MIDFETCH", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0));
    @(posedge clk); #1;
    check_all("RST_HELD", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0));
    rst_n = 1'b1;
    #1;
    check_all("REL_IDLE", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 0));
    // Late ack still high through the IDLE cycle must be ignored.
    @(posedge clk); #1;
    check_all("LATE_ACK", mk(0, 0, 0, 0, 1, 0, 0, 32'h0, 2'b00, 0, 0));

    for (int i = 0; i < tab_b.size(); i++) apply($sformatf("B%0d", i), tab_b[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
